// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and ready/valid handshake.
// Optional writeback bypass into the operands is enabled by defining ID_EX_FORWARD_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] sign_imm,
  input  logic [4:0]  shamt_in,
  input  logic [5:0]  funct,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic [4:0]  write_reg_in,
  input  logic        reg_write_in,
`ifdef ID_EX_FORWARD_EN
  input  logic        fwd_en,
  input  logic [4:0]  fwd_reg,
  input  logic [31:0] fwd_data,
`endif
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] rs_out,
  output logic [31:0] rt_out,
  output logic [4:0]  shamt_out,
  output logic [3:0]  alu_control,
  output logic [4:0]  write_reg_out,
  output logic        reg_write_out,
  output logic        illegal_op
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  logic        valid_q, valid_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [3:0]  alu_ctl_q, alu_ctl_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regw_q, regw_d;
  logic        ill_q, ill_d;

  logic        load;
  logic [3:0]  dec_ctl;
  logic        dec_ill;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign in_ready = !valid_q | out_ready;
  assign load     = in_valid & in_ready & !flush;

  always_comb begin
    dec_ctl = ALU_ADD;
    dec_ill = 1'b0;
    case (alu_op)
      2'b00: dec_ctl = ALU_ADD;
      2'b01: dec_ctl = ALU_SUB;
      2'b11: dec_ctl = ALU_AND;
      default: begin
        case (funct)
          6'b100000: dec_ctl = ALU_ADD;
          6'b100010: dec_ctl = ALU_SUB;
          6'b100100: dec_ctl = ALU_AND;
          6'b100111: dec_ctl = ALU_NOR;
          6'b101010: dec_ctl = ALU_SLT;
          6'b000000: dec_ctl = ALU_SLL;
          default: begin
            dec_ctl = ALU_ADD;
            dec_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

`ifdef ID_EX_FORWARD_EN
  // Register 0 is never bypassed: it is hardwired to zero in the file.
  assign rs_val = (fwd_en && fwd_reg != 5'd0 && fwd_reg == rs_addr) ? fwd_data : read_data1;
  assign rt_val = (fwd_en && fwd_reg != 5'd0 && fwd_reg == rt_addr) ? fwd_data : read_data2;
`else
  assign rs_val = read_data1;
  assign rt_val = read_data2;
`endif

  always_comb begin
    valid_d   = valid_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    shamt_d   = shamt_q;
    alu_ctl_d = alu_ctl_q;
    wreg_d    = wreg_q;
    regw_d    = regw_q;
    ill_d     = ill_q;
    if (flush) begin
      valid_d = 1'b0;
      regw_d  = 1'b0;
      ill_d   = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      rs_d      = rs_val;
      rt_d      = alu_src ? sign_imm : rt_val;
      shamt_d   = shamt_in;
      alu_ctl_d = dec_ctl;
      wreg_d    = write_reg_in;
      regw_d    = reg_write_in & (write_reg_in != 5'd0) & !dec_ill;
      ill_d     = dec_ill;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      shamt_q   <= '0;
      alu_ctl_q <= ALU_ADD;
      wreg_q    <= '0;
      regw_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      shamt_q   <= shamt_d;
      alu_ctl_q <= alu_ctl_d;
      wreg_q    <= wreg_d;
      regw_q    <= regw_d;
      ill_q     <= ill_d;
    end
  end

  assign out_valid     = valid_q;
  assign rs_out        = rs_q;
  assign rt_out        = rt_q;
  assign shamt_out     = shamt_q;
  assign alu_control   = alu_ctl_q;
  assign write_reg_out = wreg_q;
  assign reg_write_out = regw_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected slot contents are queued at load
// and compared every cycle the slot is valid; define ID_EX_FORWARD_EN to cover bypass.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] read_data1 = '0, read_data2 = '0, sign_imm = '0;
  logic [4:0]  shamt_in = '0;
  logic [5:0]  funct = '0;
  logic [1:0]  alu_op = '0;
  logic        alu_src = 1'b0;
  logic [4:0]  write_reg_in = '0;
  logic        reg_write_in = 1'b0;
  logic        fwd_en = 1'b0;
  logic [4:0]  fwd_reg = '0;
  logic [31:0] fwd_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] rs_out, rt_out;
  logic [4:0]  shamt_out;
  logic [3:0]  alu_control;
  logic [4:0]  write_reg_out;
  logic        reg_write_out;
  logic        illegal_op;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .read_data1(read_data1), .read_data2(read_data2),
    .sign_imm(sign_imm), .shamt_in(shamt_in), .funct(funct), .alu_op(alu_op),
    .alu_src(alu_src), .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
`ifdef ID_EX_FORWARD_EN
    .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .rs_out(rs_out), .rt_out(rt_out),
    .shamt_out(shamt_out), .alu_control(alu_control), .write_reg_out(write_reg_out),
    .reg_write_out(reg_write_out), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  sh;
    logic [3:0]  ac;
    logic [4:0]  wr;
    logic        rw;
    logic        il;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_valid = 1'b0;
  logic m_flushed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    logic [31:0] a, b;
    e.il = 1'b0;
    e.ac = 4'b0010;
    case (alu_op)
      2'b00: e.ac = 4'b0010;
      2'b01: e.ac = 4'b0110;
      2'b11: e.ac = 4'b0000;
      default:
        case (funct)
          6'b100000: e.ac = 4'b0010;
          6'b100010: e.ac = 4'b0110;
          6'b100100: e.ac = 4'b0000;
          6'b100111: e.ac = 4'b1100;
          6'b101010: e.ac = 4'b0111;
          6'b000000: e.ac = 4'b1110;
          default:   e.il = 1'b1;
        endcase
    endcase
    a = read_data1;
    b = read_data2;
`ifdef ID_EX_FORWARD_EN
    if (fwd_en && fwd_reg != 0 && fwd_reg == rs_addr) a = fwd_data;
    if (fwd_en && fwd_reg != 0 && fwd_reg == rt_addr) b = fwd_data;
`endif
    e.rs = a;
    e.rt = alu_src ? sign_imm : b;
    e.sh = shamt_in;
    e.wr = write_reg_in;
    e.rw = reg_write_in && write_reg_in != 0 && !e.il;
    return e;
  endfunction

  // Checks the current slot against the model, then advances one clock edge.
  task automatic step();
    logic m_ready, ld;
    exp_t e;
    #1;
    m_ready = !m_valid || out_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid && q.size() > 0) begin
      e = q[0];
      chk("rs_out", rs_out, e.rs);
      chk("rt_out", rt_out, e.rt);
      chk("shamt_out", {27'd0, shamt_out}, {27'd0, e.sh});
      chk("alu_control", {28'd0, alu_control}, {28'd0, e.ac});
      chk("write_reg_out", {27'd0, write_reg_out}, {27'd0, e.wr});
      chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.il});
      if (out_ready || flush) void'(q.pop_front());
    end else if (m_flushed) begin
      chk("flush_regw", {31'd0, reg_write_out}, 32'd0);
      chk("flush_ill", {31'd0, illegal_op}, 32'd0);
    end
    ld = in_valid && m_ready && !flush;
    if (ld) q.push_back(model_exp());
    m_flushed = flush;
    if (flush) m_valid = 1'b0;
    else if (ld) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic src, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] wr,
                     input logic rw, input logic rdy, input logic fl);
    in_valid = v; alu_op = op; funct = fn; alu_src = src;
    read_data1 = d1; read_data2 = d2; sign_imm = imm; shamt_in = sh;
    write_reg_in = wr; reg_write_in = rw; out_ready = rdy; flush = fl;
  endtask

  logic [5:0] fn_tab [8];

  initial begin
    fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
    fn_tab[3] = 6'b100111; fn_tab[4] = 6'b101010; fn_tab[5] = 6'b000000;
    fn_tab[6] = 6'b111111; fn_tab[7] = 6'b010101;

    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_aluctl", {28'd0, alu_control}, 32'h2);
    chk("rst_rs", rs_out, 32'd0);
    chk("rst_rt", rt_out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Decode sweep
    drv(1, 2'b10, 6'b101010, 0, 32'd5, 32'd9, 32'h77, 5'd0, 5'd3, 1, 1, 0); step();
    drv(1, 2'b10, 6'b000000, 0, 32'd1, 32'd2, 32'h0, 5'd4, 5'd4, 1, 1, 0); step();
    drv(1, 2'b00, 6'b111111, 1, 32'd10, 32'd11, 32'hFFFF_FFF0, 5'd1, 5'd5, 1, 1, 0); step();
    drv(1, 2'b01, 6'b000000, 0, 32'd20, 32'd21, 32'h0, 5'd2, 5'd6, 0, 1, 0); step();
    drv(1, 2'b11, 6'b000000, 1, 32'd30, 32'd31, 32'h1234, 5'd3, 5'd7, 1, 1, 0); step();
    drv(1, 2'b10, 6'b100111, 0, 32'd40, 32'd41, 32'h0, 5'd5, 5'd8, 1, 1, 0); step();
    drv(1, 2'b10, 6'b100010, 0, 32'd50, 32'd51, 32'h0, 5'd6, 5'd9, 1, 1, 0); step();
    // Illegal funct, then write to register 0
    drv(1, 2'b10, 6'b111111, 0, 32'd60, 32'd61, 32'h0, 5'd7, 5'd10, 1, 1, 0); step();
    drv(1, 2'b10, 6'b100000, 0, 32'd70, 32'd71, 32'h0, 5'd8, 5'd0, 1, 1, 0); step();
    drv(0, 2'b00, 6'b000000, 0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 0, 1, 0); step();

    // Backpressure: A held while B waits, then B replaces A without a bubble
    drv(1, 2'b10, 6'b100100, 0, 32'hA1, 32'hA2, 32'h0, 5'd9, 5'd11, 1, 1, 0); step();
    drv(1, 2'b00, 6'b000000, 1, 32'hB1, 32'hB2, 32'hB3, 5'd10, 5'd12, 1, 0, 0);
    repeat (3) step();
    out_ready = 1'b1; step();
    in_valid = 1'b0; out_ready = 1'b0; step();

    // Flush while held under backpressure with a new instruction presented
    drv(1, 2'b10, 6'b100000, 0, 32'hC1, 32'hC2, 32'h0, 5'd11, 5'd13, 1, 0, 1); step();
    drv(0, 2'b00, 6'b000000, 0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0); step();
    step();

    // Reset asserted mid-cycle with an instruction held
    drv(1, 2'b01, 6'b000000, 0, 32'hD1, 32'hD2, 32'h0, 5'd12, 5'd14, 1, 0, 0); step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_aluctl", {28'd0, alu_control}, 32'h2);
    chk("midrst_regw", {31'd0, reg_write_out}, 32'd0);
    chk("midrst_rs", rs_out, 32'd0);
    q.delete();
    m_valid = 1'b0;
    m_flushed = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(1, 2'b10, 6'b101010, 0, 32'hE1, 32'hE2, 32'h0, 5'd13, 5'd15, 1, 0, 0); step();
    out_ready = 1'b1; in_valid = 1'b0; step();
    step();

`ifdef ID_EX_FORWARD_EN
    rs_addr = 5'd7; rt_addr = 5'd7; fwd_en = 1'b1; fwd_reg = 5'd7; fwd_data = 32'hDEADBEEF;
    drv(1, 2'b00, 6'b000000, 0, 32'h11, 32'h22, 32'h0, 5'd0, 5'd16, 1, 1, 0); step();
    fwd_reg = 5'd0;
    drv(1, 2'b00, 6'b000000, 0, 32'h33, 32'h44, 32'h0, 5'd0, 5'd17, 1, 1, 0); step();
    in_valid = 1'b0; step();
`endif

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), fn_tab[$urandom_range(0, 7)],
          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
`ifdef ID_EX_FORWARD_EN
      rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
      fwd_en = 1'($urandom_range(0, 1)); fwd_reg = 5'($urandom_range(0, 3)); fwd_data = $urandom;
`endif
      step();
    end
    drv(0, 2'b00, 6'b000000, 0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 0, 1, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
